// File: rtl/cs_input_cond.sv
// ----------------------------------------------------------------------------
// cs_input_cond
//   Player-input conditioning between the joystick merge and the game core.
//   Raw button bits are synchronised into clk_sys, debounced per bit,
//   contradictory rotation is suppressed, and every coin press is shaped into
//   a single fixed-width pulse followed by a dead time.
//
// Ports
//   clk_sys    in  1  system clock, all logic on the rising edge
//   reset      in  1  asynchronous active-high reset
//   joy_in     in  8  raw buttons (0 right, 1 left, 4 thrust, 5 fire,
//                     6 start, 7 coin; 2-3 unused)
//   m_cw       out 1  rotate clockwise (right only)
//   m_ccw      out 1  rotate counter-clockwise (left only)
//   m_thrust   out 1  debounced thrust
//   m_fire     out 1  debounced fire
//   m_start    out 1  debounced start
//   m_coin     out 1  shaped coin pulse
//   coin_count out 8  coin pulses issued, mod 256
// ----------------------------------------------------------------------------
module cs_input_cond #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int COIN_PULSE_CYCLES = 2500000,
    parameter int COIN_GAP_CYCLES   = 5000000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] joy_in,
    output logic       m_cw,
    output logic       m_ccw,
    output logic       m_thrust,
    output logic       m_fire,
    output logic       m_start,
    output logic       m_coin,
    output logic [7:0] coin_count
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int T_MAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                           COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
    localparam int TM_W  = $clog2(T_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] PULSE_LAST = TM_W'(COIN_PULSE_CYCLES - 1);
    localparam logic [TM_W-1:0] GAP_LAST   = TM_W'(COIN_GAP_CYCLES - 1);

    // Internal bit order: 0 right, 1 left, 2 thrust, 3 fire, 4 start, 5 coin
    localparam int N_BITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_GAP      = 2'd2,
        ST_WAIT_REL = 2'd3
    } coin_state_t;

    logic [N_BITS-1:0] raw_s;
    logic              unused_joy_s;
    logic [N_BITS-1:0] sync1_r;
    logic [N_BITS-1:0] sync2_r;
    logic [N_BITS-1:0] deb_r;
    logic [DB_W-1:0]   db_cnt_r [N_BITS];

    coin_state_t       coin_state_r;
    logic [TM_W-1:0]   coin_timer_r;
    logic [7:0]        coin_count_r;
    logic              m_coin_r;
    logic              m_cw_r;
    logic              m_ccw_r;
    logic              m_thrust_r;
    logic              m_fire_r;
    logic              m_start_r;

    assign raw_s        = {joy_in[7:4], joy_in[1:0]};
    assign unused_joy_s = ^joy_in[3:2];

    // Two-flop synchroniser for each used button bit
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debouncer: the state only flips after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement with the synced input
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            deb_r <= '0;
            for (int i = 0; i < N_BITS; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BITS; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    // This increment reaches DEBOUNCE_CYCLES: commit the new level
                    db_cnt_r[i] <= '0;
                    deb_r[i]    <= ~deb_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Registered rotation (conflict suppressed) and pass-through buttons
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_cw_r     <= 1'b0;
            m_ccw_r    <= 1'b0;
            m_thrust_r <= 1'b0;
            m_fire_r   <= 1'b0;
            m_start_r  <= 1'b0;
        end else begin
            m_cw_r     <= deb_r[0] & ~deb_r[1];
            m_ccw_r    <= deb_r[1] & ~deb_r[0];
            m_thrust_r <= deb_r[2];
            m_fire_r   <= deb_r[3];
            m_start_r  <= deb_r[4];
        end
    end

    // Coin shaper: one pulse per press, dead time afterwards, and the coin
    // must be seen released before another press is accepted
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            coin_state_r <= ST_IDLE;
            coin_timer_r <= '0;
            coin_count_r <= 8'd0;
            m_coin_r     <= 1'b0;
        end else begin
            case (coin_state_r)
                ST_IDLE: begin
                    if (deb_r[5]) begin
                        coin_state_r <= ST_PULSE;
                        coin_timer_r <= '0;
                        coin_count_r <= coin_count_r + 8'd1;
                        m_coin_r     <= 1'b1;
                    end else begin
                        m_coin_r     <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (coin_timer_r == PULSE_LAST) begin
                        coin_state_r <= ST_GAP;
                        coin_timer_r <= '0;
                        m_coin_r     <= 1'b0;
                    end else begin
                        coin_timer_r <= coin_timer_r + TM_W'(1);
                        m_coin_r     <= 1'b1;
                    end
                end
                ST_GAP: begin
                    m_coin_r <= 1'b0;
                    if (coin_timer_r == GAP_LAST) begin
                        coin_state_r <= ST_WAIT_REL;
                        coin_timer_r <= '0;
                    end else begin
                        coin_timer_r <= coin_timer_r + TM_W'(1);
                    end
                end
                ST_WAIT_REL: begin
                    m_coin_r <= 1'b0;
                    if (!deb_r[5]) begin
                        coin_state_r <= ST_IDLE;
                    end else begin
                        coin_state_r <= ST_WAIT_REL;
                    end
                end
                default: begin
                    coin_state_r <= ST_IDLE;
                    coin_timer_r <= '0;
                    m_coin_r     <= 1'b0;
                end
            endcase
        end
    end

    assign m_cw       = m_cw_r;
    assign m_ccw      = m_ccw_r;
    assign m_thrust   = m_thrust_r;
    assign m_fire     = m_fire_r;
    assign m_start    = m_start_r;
    assign m_coin     = m_coin_r;
    assign coin_count = coin_count_r;

endmodule

// File: tb/tb_cs_input_cond.sv
// ----------------------------------------------------------------------------
// tb_cs_input_cond
//   Directed bench for cs_input_cond with DEBOUNCE_CYCLES=4,
//   COIN_PULSE_CYCLES=8, COIN_GAP_CYCLES=6. Inputs change 1 time unit after
//   a rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_cs_input_cond;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] joy_in  = 8'd0;
    logic       m_cw, m_ccw, m_thrust, m_fire, m_start, m_coin;
    logic [7:0] coin_count;

    int n_tests = 0;
    int n_fail  = 0;

    // coin pulse monitor, updated on every tick
    int   cyc        = 0;
    int   rises      = 0;
    int   last_rise  = 0;
    int   width      = 0;
    int   last_width = 0;
    logic coin_prev  = 1'b0;

    cs_input_cond #(
        .DEBOUNCE_CYCLES  (4),
        .COIN_PULSE_CYCLES(8),
        .COIN_GAP_CYCLES  (6)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .joy_in    (joy_in),
        .m_cw      (m_cw),
        .m_ccw     (m_ccw),
        .m_thrust  (m_thrust),
        .m_fire    (m_fire),
        .m_start   (m_start),
        .m_coin    (m_coin),
        .coin_count(coin_count)
    );

    // 100 MHz bench clock
    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        cyc++;
        if (m_coin && !coin_prev) begin
            rises++;
            last_rise = cyc;
            width     = 0;
        end
        if (m_coin) width++;
        if (!m_coin && coin_prev) last_width = width;
        coin_prev = m_coin;
    endtask

    initial begin
        int   t0;
        int   r1;
        logic seen;

        // ---------------- reset and debounce timing ----------------
        repeat (3) tick();
        joy_in[4] = 1'b1;
        repeat (3) tick();
        check_eq("outs_in_reset",
                 {19'd0, m_cw, m_ccw, m_thrust, m_fire, m_start, m_coin, coin_count},
                 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) check_eq("thrust_edge6", {31'd0, m_thrust}, 32'd0);
            if (k == 7) check_eq("thrust_edge7", {31'd0, m_thrust}, 32'd1);
        end
        joy_in[4] = 1'b0;
        repeat (10) tick();
        check_eq("thrust_release", {31'd0, m_thrust}, 32'd0);

        // ---------------- glitch rejection ----------------
        seen = 1'b0;
        joy_in[5] = 1'b1;
        repeat (3) tick();
        joy_in[5] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen |= m_fire;
        end
        check_eq("fire_glitch3", {31'd0, seen}, 32'd0);
        seen = 1'b0;
        joy_in[5] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen |= m_fire;
        end
        joy_in[5] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen |= m_fire;
        end
        check_eq("fire_pulse5", {31'd0, seen}, 32'd1);
        repeat (10) tick();
        check_eq("fire_settled", {31'd0, m_fire}, 32'd0);

        // ---------------- rotation conflict ----------------
        joy_in[1] = 1'b1;
        repeat (10) tick();
        check_eq("rot_left", {30'd0, m_cw, m_ccw}, 32'd1);
        joy_in[0] = 1'b1;
        repeat (10) tick();
        check_eq("rot_both", {30'd0, m_cw, m_ccw}, 32'd0);
        joy_in[1] = 1'b0;
        repeat (10) tick();
        check_eq("rot_right", {30'd0, m_cw, m_ccw}, 32'd2);
        joy_in[0] = 1'b0;
        repeat (10) tick();
        check_eq("rot_none", {30'd0, m_cw, m_ccw}, 32'd0);

        // ---------------- held coin ----------------
        rises = 0;
        t0 = cyc;
        joy_in[7] = 1'b1;
        repeat (200) tick();
        check_eq("held_rises", rises, 32'd1);
        check_eq("held_width", last_width, 32'd8);
        check_eq("held_rise_at", last_rise - t0, 32'd7);
        check_eq("held_count", {24'd0, coin_count}, 32'd1);
        joy_in[7] = 1'b0;
        repeat (20) tick();
        rises = 0;
        joy_in[7] = 1'b1;
        repeat (30) tick();
        check_eq("second_rises", rises, 32'd1);
        check_eq("second_count", {24'd0, coin_count}, 32'd2);
        joy_in[7] = 1'b0;
        repeat (20) tick();

        // ---------------- coin bounce during pulse and gap ----------------
        rises = 0;
        joy_in[7] = 1'b1;
        repeat (7) tick();
        check_eq("bounce_rise", {31'd0, m_coin}, 32'd1);
        r1 = last_rise;
        joy_in[7] = 1'b0;
        repeat (5) tick();
        joy_in[7] = 1'b1;
        repeat (5) tick();
        joy_in[7] = 1'b0;
        repeat (30) tick();
        check_eq("bounce_rises", rises, 32'd1);
        check_eq("bounce_count", {24'd0, coin_count}, 32'd3);
        t0 = cyc;
        joy_in[7] = 1'b1;
        repeat (20) tick();
        check_eq("repress_rises", rises, 32'd2);
        check_eq("repress_spacing", {31'd0, (last_rise - r1) >= 15}, 32'd1);
        check_eq("repress_rise_at", last_rise - t0, 32'd7);
        check_eq("repress_count", {24'd0, coin_count}, 32'd4);
        joy_in[7] = 1'b0;
        repeat (25) tick();

        // ---------------- reset mid-pulse ----------------
        joy_in[7] = 1'b1;
        repeat (10) tick();
        check_eq("midpulse_coin", {31'd0, m_coin}, 32'd1);
        check_eq("midpulse_count", {24'd0, coin_count}, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_coin", {31'd0, m_coin}, 32'd0);
        check_eq("async_count", {24'd0, coin_count}, 32'd0);
        repeat (2) tick();
        rises = 0;
        reset = 1'b0;
        t0 = cyc;
        repeat (20) tick();
        check_eq("post_reset_rise_at", last_rise - t0, 32'd7);
        check_eq("post_reset_count", {24'd0, coin_count}, 32'd1);
        joy_in[7] = 1'b0;
        repeat (25) tick();

        // ---------------- counter wrap ----------------
        rises = 0;
        for (int p = 0; p < 255; p++) begin
            joy_in[7] = 1'b1;
            repeat (10) tick();
            joy_in[7] = 1'b0;
            repeat (25) tick();
            if (p == 253) check_eq("count_255", {24'd0, coin_count}, 32'd255);
        end
        check_eq("wrap_rises", rises, 32'd255);
        check_eq("wrap_count", {24'd0, coin_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
